// File: rtl/parking_gate_ctrl.sv
// Entry/exit direction sequencer for one parking lane: decodes the outer (A) and inner (B) beam
// order, tracks occupancy and emits single-cycle event pulses for display and barrier logic.
module parking_gate_ctrl #(
    parameter int unsigned CAPACITY = 16,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned TIMEOUT  = 250_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             reject_pulse,
    output logic             fault_pulse,
    output logic [2:0]       state_o
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] IN_A   = 3'd1;
    localparam logic [2:0] IN_AB  = 3'd2;
    localparam logic [2:0] IN_B   = 3'd3;
    localparam logic [2:0] OUT_B  = 3'd4;
    localparam logic [2:0] OUT_BA = 3'd5;
    localparam logic [2:0] OUT_A  = 3'd6;

    localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACITY);
    localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic             entry_q, entry_d;
    logic             exit_q, exit_d;
    logic             reject_q, reject_d;
    logic             fault_q, fault_d;
    logic             ev_entry, ev_exit, ev_fault;
    logic [1:0]       ab;

    assign ab = {sensor_a, sensor_b};

    always_comb begin
        state_d  = state_q;
        ev_entry = 1'b0;
        ev_exit  = 1'b0;
        ev_fault = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = IN_A;
                    2'b01:   state_d = OUT_B;
                    2'b11:   ev_fault = 1'b1;
                    default: state_d = IDLE;
                endcase
            end
            IN_A: begin
                case (ab)
                    2'b11:   state_d = IN_AB;
                    2'b00:   state_d = IDLE;
                    2'b01:   begin state_d = IDLE; ev_fault = 1'b1; end
                    default: state_d = IN_A;
                endcase
            end
            IN_AB: begin
                case (ab)
                    2'b01:   state_d = IN_B;
                    2'b10:   state_d = IN_A;
                    2'b00:   begin state_d = IDLE; ev_fault = 1'b1; end
                    default: state_d = IN_AB;
                endcase
            end
            IN_B: begin
                case (ab)
                    2'b11:   state_d = IN_AB;
                    2'b00:   begin state_d = IDLE; ev_entry = 1'b1; end
                    2'b10:   begin state_d = IDLE; ev_fault = 1'b1; end
                    default: state_d = IN_B;
                endcase
            end
            OUT_B: begin
                case (ab)
                    2'b11:   state_d = OUT_BA;
                    2'b00:   state_d = IDLE;
                    2'b10:   begin state_d = IDLE; ev_fault = 1'b1; end
                    default: state_d = OUT_B;
                endcase
            end
            OUT_BA: begin
                case (ab)
                    2'b10:   state_d = OUT_A;
                    2'b01:   state_d = OUT_B;
                    2'b00:   begin state_d = IDLE; ev_fault = 1'b1; end
                    default: state_d = OUT_BA;
                endcase
            end
            OUT_A: begin
                case (ab)
                    2'b11:   state_d = OUT_BA;
                    2'b00:   begin state_d = IDLE; ev_exit = 1'b1; end
                    2'b01:   begin state_d = IDLE; ev_fault = 1'b1; end
                    default: state_d = OUT_A;
                endcase
            end
            default: state_d = IDLE;
        endcase

        // A stalled sequence times out only if no state change happens on that edge.
        if (state_q != IDLE && state_d == state_q && timer_q == TLAST) begin
            state_d  = IDLE;
            ev_fault = 1'b1;
        end

        timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + 1'b1;

        entry_d  = ev_entry && (occ_q < CAP);
        reject_d = ev_entry && (occ_q >= CAP);
        exit_d   = ev_exit && (occ_q != '0);
        fault_d  = ev_fault || (ev_exit && occ_q == '0);

        occ_d = occ_q;
        if (entry_d) begin
            occ_d = occ_q + 1'b1;
        end else if (exit_d) begin
            occ_d = occ_q - 1'b1;
        end
        full_d = (occ_d == CAP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
            reject_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            entry_q  <= entry_d;
            exit_q   <= exit_d;
            reject_q <= reject_d;
            fault_q  <= fault_d;
        end
    end

    assign occupancy    = occ_q;
    assign full         = full_q;
    assign entry_pulse  = entry_q;
    assign exit_pulse   = exit_q;
    assign reject_pulse = reject_q;
    assign fault_pulse  = fault_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with CAPACITY=3, CNT_W=2, TIMEOUT=100.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_a = 1'b0;
    logic       sensor_b = 1'b0;
    logic [1:0] occupancy;
    logic       full;
    logic       entry_pulse, exit_pulse, reject_pulse, fault_pulse;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int ent_cnt, ext_cnt, rej_cnt, flt_cnt;

    parking_gate_ctrl #(
        .CAPACITY(3),
        .CNT_W   (2),
        .TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_a    (sensor_a),
        .sensor_b    (sensor_b),
        .occupancy   (occupancy),
        .full        (full),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .reject_pulse(reject_pulse),
        .fault_pulse (fault_pulse),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (entry_pulse)  ent_cnt++;
        if (exit_pulse)   ext_cnt++;
        if (reject_pulse) rej_cnt++;
        if (fault_pulse)  flt_cnt++;
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        {sensor_a, sensor_b} = ab;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr();
        ent_cnt = 0;
        ext_cnt = 0;
        rej_cnt = 0;
        flt_cnt = 0;
    endtask

    task automatic do_entry();
        hold(2'b10, 3);
        hold(2'b11, 3);
        hold(2'b01, 3);
        hold(2'b00, 3);
    endtask

    task automatic do_exit();
        hold(2'b01, 3);
        hold(2'b11, 3);
        hold(2'b10, 3);
        hold(2'b00, 3);
    endtask

    initial begin
        clr();
        // Reset state
        hold(2'b00, 2);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_pulses", 32'({entry_pulse, exit_pulse, reject_pulse, fault_pulse}), 0);
        rst_n = 1'b1;

        // 1. Single entry, pulse timing
        clr();
        hold(2'b00, 5);
        hold(2'b10, 5);
        chk("t1_in_a", 32'(state_o), 1);
        hold(2'b11, 5);
        chk("t1_in_ab", 32'(state_o), 2);
        hold(2'b01, 5);
        chk("t1_in_b", 32'(state_o), 3);
        hold(2'b00, 1);
        chk("t1_entry_pulse", 32'(entry_pulse), 1);
        chk("t1_occ", 32'(occupancy), 1);
        chk("t1_idle", 32'(state_o), 0);
        hold(2'b00, 1);
        chk("t1_pulse_1cyc", 32'(entry_pulse), 0);
        chk("t1_no_fault", 32'(flt_cnt), 0);

        // 2. Fill to capacity, then reject
        clr();
        do_entry();
        do_entry();
        chk("t2_entries", 32'(ent_cnt), 2);
        chk("t2_occ_full", 32'(occupancy), 3);
        chk("t2_full", 32'(full), 1);
        do_entry();
        chk("t2_reject", 32'(rej_cnt), 1);
        chk("t2_no_extra_entry", 32'(ent_cnt), 2);
        chk("t2_occ_held", 32'(occupancy), 3);

        // 3. Exit at full
        clr();
        hold(2'b01, 5);
        chk("t3_out_b", 32'(state_o), 4);
        hold(2'b11, 5);
        chk("t3_out_ba", 32'(state_o), 5);
        hold(2'b10, 5);
        chk("t3_out_a", 32'(state_o), 6);
        hold(2'b00, 1);
        chk("t3_exit_pulse", 32'(exit_pulse), 1);
        chk("t3_occ", 32'(occupancy), 2);
        chk("t3_full_clear", 32'(full), 0);

        // 4. Underflow, back-out, illegal 00->11
        do_exit();
        do_exit();
        chk("t4_occ_zero", 32'(occupancy), 0);
        clr();
        do_exit();
        chk("t4_underflow_fault", 32'(flt_cnt), 1);
        chk("t4_underflow_no_exit", 32'(ext_cnt), 0);
        chk("t4_occ_no_wrap", 32'(occupancy), 0);
        clr();
        hold(2'b10, 3);
        hold(2'b00, 3);
        chk("t4_backout_pulses", 32'(ent_cnt + ext_cnt + rej_cnt + flt_cnt), 0);
        chk("t4_backout_idle", 32'(state_o), 0);
        hold(2'b11, 1);
        chk("t4_illegal_fault", 32'(fault_pulse), 1);
        chk("t4_illegal_idle", 32'(state_o), 0);
        hold(2'b00, 3);

        // 5. Timeout after exactly 100 cycles in IN_A
        clr();
        hold(2'b10, 1);
        chk("t5_in_a", 32'(state_o), 1);
        hold(2'b10, 99);
        chk("t5_no_early_fault", 32'(flt_cnt), 0);
        hold(2'b10, 1);
        chk("t5_timeout_fault", 32'(fault_pulse), 1);
        chk("t5_timeout_idle", 32'(state_o), 0);
        hold(2'b10, 1);
        chk("t5_reenter", 32'(state_o), 1);
        chk("t5_fault_1cyc", 32'(fault_pulse), 0);
        hold(2'b10, 48);
        chk("t5_single_fault", 32'(flt_cnt), 1);
        hold(2'b00, 3);

        // Legal transition on the timeout edge wins
        clr();
        hold(2'b10, 100);
        hold(2'b11, 1);
        chk("t5_legal_wins_state", 32'(state_o), 2);
        chk("t5_legal_wins_nofault", 32'(flt_cnt), 0);
        hold(2'b01, 3);
        hold(2'b00, 3);
        chk("t5_entry_after", 32'(ent_cnt), 1);
        chk("t5_occ", 32'(occupancy), 1);

        // 6. Reset mid-sequence in IN_B with occupancy 2
        clr();
        do_entry();
        chk("t6_occ_two", 32'(occupancy), 2);
        hold(2'b10, 3);
        hold(2'b11, 3);
        hold(2'b01, 3);
        chk("t6_in_b", 32'(state_o), 3);
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_occ", 32'(occupancy), 0);
        chk("t6_rst_state", 32'(state_o), 0);
        rst_n = 1'b1;
        clr();
        hold(2'b00, 3);
        chk("t6_no_entry", 32'(ent_cnt), 0);
        chk("t6_still_zero", 32'(occupancy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
